clocked_mux: RTL and testbench

CLOCKED_MUX -- requirements
Module: clocked_mux

---
 rtl/clocked_mux_pkg.sv | 10 +
 rtl/clocked_mux_sat_cnt.sv | 40 ++++
 rtl/clocked_mux.sv | 67 ++++++
 tb/tb_clocked_mux.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/clocked_mux_pkg.sv
// Shared defaults and select encodings for the clocked_mux slice.
package clocked_mux_pkg;

    localparam int unsigned DEF_WIDTH = 1;
    localparam int unsigned DEF_CNT_W = 8;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

endpackage

// File: rtl/clocked_mux_sat_cnt.sv
// Saturating up-counter: counts inc_i pulses and sticks at all-ones.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   inc_i       - increment request for this cycle
//   cnt_o       - registered count value
module clocked_mux_sat_cnt
    import clocked_mux_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: hold at CNT_MAX instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/clocked_mux.sv
// Registered 2:1 mux with source-change detection and optional change counter.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   sel             - source select (SEL_D0 -> d_in0, SEL_D1 -> d_in1)
//   d_in0, d_in1    - data sources, WIDTH bits
//   d_out           - registered mux output, 1-cycle latency
//   switched        - registered one-cycle pulse after sel changes
//   switch_cnt      - saturating count of sel changes
// Build option: define CLOCKED_MUX_SWITCH_CNT_EN to include the switch counter;
// otherwise switch_cnt is tied to zero and no counter flops exist.
module clocked_mux
    import clocked_mux_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [WIDTH-1:0] d_in0,
    input  logic [WIDTH-1:0] d_in1,
    output logic [WIDTH-1:0] d_out,
    output logic             switched,
    output logic [CNT_W-1:0] switch_cnt
);

    logic [WIDTH-1:0] d_out_q;
    logic [WIDTH-1:0] d_out_d;
    logic             sel_q;
    logic             switched_q;
    logic             sel_change_c;

    // sel_q resets to SEL_D0, so a first post-reset sel=1 counts as a change.
    assign sel_change_c = (sel != sel_q);
    assign d_out_d      = (sel == SEL_D1) ? d_in1 : d_in0;

    // Select/data path registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out_q    <= RESET_VALUE;
            sel_q      <= SEL_D0;
            switched_q <= 1'b0;
        end else begin
            d_out_q    <= d_out_d;
            sel_q      <= sel;
            switched_q <= sel_change_c;
        end
    end

    assign d_out    = d_out_q;
    assign switched = switched_q;

`ifdef CLOCKED_MUX_SWITCH_CNT_EN
    clocked_mux_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (sel_change_c),
        .cnt_o (switch_cnt)
    );
`else
    assign switch_cnt = '0;
`endif

endmodule

// File: tb/tb_clocked_mux.sv
// Scoreboard bench for clocked_mux (WIDTH=8, CNT_W=3). Stimulus pushes the
// hand-computed expected outputs for each edge; the monitor pops and compares.
module tb_clocked_mux;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          reset;
    logic          sel;
    logic [W-1:0]  d_in0;
    logic [W-1:0]  d_in1;
    logic [W-1:0]  d_out;
    logic          switched;
    logic [CW-1:0] switch_cnt;

    typedef struct {
        string         name;
        logic [W-1:0]  dout;
        logic          sw;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    clocked_mux #(
        .WIDTH       (W),
        .RESET_VALUE (8'h00),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .d_in0      (d_in0),
        .d_in1      (d_in1),
        .d_out      (d_out),
        .switched   (switched),
        .switch_cnt (switch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter expectation depends on whether the counter is built in.
    function automatic logic [CW-1:0] ce(input int v);
`ifdef CLOCKED_MUX_SWITCH_CNT_EN
        return CW'(v);
`else
        return (v == 0) ? CW'(0) : CW'(0);
`endif
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic step(input string nm, input logic r, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic es, input int ec);
        exp_t e;
        @(negedge clk);
        reset = r;
        sel   = s;
        d_in0 = a;
        d_in1 = b;
        e.name = nm;
        e.dout = ed;
        e.sw   = es;
        e.cnt  = ce(ec);
        exp_q.push_back(e);
    endtask

    // Monitor: every edge with a pending expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (d_out !== e.dout) begin
                    failures++;
                    $display("FAIL %s d_out: got %0h expected %0h", e.name, d_out, e.dout);
                end
                checks++;
                if (switched !== e.sw) begin
                    failures++;
                    $display("FAIL %s switched: got %0b expected %0b", e.name, switched, e.sw);
                end
                checks++;
                if (switch_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL %s switch_cnt: got %0d expected %0d", e.name, switch_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        sel   = 1'b1;
        d_in0 = 8'h00;
        d_in1 = 8'h01;

        // Reset held two edges with sel=1, d_in1=1.
        step("rst0", 1, 1, 8'h00, 8'h01, 8'h00, 0, 0);
        step("rst1", 1, 1, 8'h00, 8'h01, 8'h00, 0, 0);

        // Static select of d_in0.
        for (int i = 0; i < 3; i++) step("static", 0, 0, 8'h00, 8'h01, 8'h00, 0, 0);

        // Toggle pattern 0,0,1,0,1,0,1,0 -> six switches.
        step("tog0", 0, 0, 8'h00, 8'h01, 8'h00, 0, 0);
        step("tog1", 0, 0, 8'h00, 8'h01, 8'h00, 0, 0);
        step("tog2", 0, 1, 8'h00, 8'h01, 8'h01, 1, 1);
        step("tog3", 0, 0, 8'h00, 8'h01, 8'h00, 1, 2);
        step("tog4", 0, 1, 8'h00, 8'h01, 8'h01, 1, 3);
        step("tog5", 0, 0, 8'h00, 8'h01, 8'h00, 1, 4);
        step("tog6", 0, 1, 8'h00, 8'h01, 8'h01, 1, 5);
        step("tog7", 0, 0, 8'h00, 8'h01, 8'h00, 1, 6);
        step("hold", 0, 0, 8'h00, 8'h01, 8'h00, 0, 6);

        // Saturation: ten toggles, counter reaches 7 and stays.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) step("sat", 0, 1, 8'h00, 8'h01, 8'h01, 1, 7);
            else            step("sat", 0, 0, 8'h00, 8'h01, 8'h00, 1, 7);
        end

        // Clear, then build up to count 4 with d_out=1.
        step("clr", 1, 0, 8'h00, 8'h01, 8'h00, 0, 0);
        step("up1", 0, 1, 8'h00, 8'h01, 8'h01, 1, 1);
        step("up2", 0, 0, 8'h00, 8'h01, 8'h00, 1, 2);
        step("up3", 0, 1, 8'h00, 8'h01, 8'h01, 1, 3);
        step("up4", 0, 0, 8'h00, 8'h01, 8'h00, 1, 4);
        step("up4d", 0, 0, 8'h01, 8'h01, 8'h01, 0, 4);

        // Mid-run reset with sel changing: reset wins.
        step("midrst", 1, 1, 8'h01, 8'h01, 8'h00, 0, 0);

        // First edge after reset with sel=1 counts as a switch.
        step("post_rst", 0, 1, 8'h00, 8'h01, 8'h01, 1, 1);

        // Width: distinct 8-bit sources.
        step("w_a5", 0, 0, 8'hA5, 8'h3C, 8'hA5, 1, 2);
        step("w_3c", 0, 1, 8'hA5, 8'h3C, 8'h3C, 1, 3);

        // Data changes with sel held: follow data, no switch.
        step("data5a", 0, 1, 8'hA5, 8'h5A, 8'h5A, 0, 3);
        step("dataff", 0, 1, 8'h00, 8'hFF, 8'hFF, 0, 3);

        // Drain the scoreboard within a bounded number of edges.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
